lockstep_cmp_mon: RTL and testbench
===================================

// Module: lockstep_cmp_mon
// PURPOSE
//  Synthesizable lockstep monitor comparing NCH gold/DUT output channels (e.g. gps vs gps_lbll
//  ca_code/p_code/l_code/l_code_valid) every cycle inside a qualified check window.
//  Gives per-channel sticky flags, saturating mismatch counters and a first-mismatch snapshot.
//  Used on-chip/FPGA for key-correctness checks of locked designs; bench drives it same as RTL.
// PARAMETERS
//  NCH     4    number of compared channels
//  WIDTH   128  bits per channel (narrower signals zero-extended by the instantiator)
//  CNT_W   16   per-channel mismatch counter width (saturating)
//  TS_W    32   timestamp / active-cycle counter width (saturating)
//  SETTLE  4    cycles after check window opens before comparisons count (0 = immediate)
// PORTS
//  sys_clk_50      in   1          clock, all state on rising edge
//  reset           in   1          asynchronous, active-high reset
//  chk_en          in   1          check window qualifier
//  clr             in   1          synchronous clear of all results
//  ch_mask         in   NCH        1 = channel compared, 0 = ignored
//  gold_bus        in   NCH*WIDTH  golden outputs, channel i at [i*WIDTH +: WIDTH]
//  dut_bus         in   NCH*WIDTH  DUT outputs, same packing
//  mismatch_now    out  NCH        registered per-channel mismatch of previous cycle
//  mismatch_sticky out  NCH        per-channel sticky error
//  any_err         out  1          OR of mismatch_sticky
//  mismatch_cnt    out  NCH*CNT_W  per-channel saturating counts
//  cycle_cnt       out  TS_W       compared (ACTIVE) cycles, saturating
//  first_valid     out  1          first-mismatch snapshot held
//  first_ch        out  CH_W       channel of first mismatch, CH_W = max(1,$clog2(NCH))
//  first_time      out  TS_W       cycle_cnt value at first mismatch
//  first_gold      out  WIDTH      gold word at first mismatch
//  first_dut       out  WIDTH      DUT word at first mismatch
// BEHAVIOUR
//  - reset: every output and internal register 0, FSM = IDLE.
//  - FSM IDLE -> (chk_en) SETTLE, or ACTIVE directly when SETTLE==0; SETTLE counts SETTLE
//    cycles then ACTIVE; chk_en low in any state -> IDLE next edge, settle counter reset.
//  - Compare only in ACTIVE: hit[i] = ch_mask[i] && gold_i != dut_i, sampled at edge k,
//    visible on outputs after edge k (latency 1). Outside ACTIVE hit = 0.
//  - mismatch_now = hit every edge (cleared outside ACTIVE). sticky |= hit. cnt[i] += hit[i],
//    holds at 2^CNT_W-1. cycle_cnt +1 per ACTIVE edge, holds at 2^TS_W-1.
//  - first capture only while first_valid==0: lowest-index hit channel wins on ties;
//    first_time = cycle_cnt before that edge's increment.
//  - Leaving ACTIVE keeps sticky/counts/snapshot; re-entry goes through SETTLE again.
//  - clr: priority over same-cycle hits; zeroes sticky, counters, cycle_cnt, snapshot,
//    mismatch_now; FSM state unaffected.
//  - Async reset mid-window: immediate clear, IDLE; no partial snapshot survives.
//  - ch_mask change takes effect the same edge; masked channel counters freeze.
// STRUCTURE
//  - lockstep_pkg: typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE} lk_state_t;
//    sat_inc function (width-generic via parameterised class static or fixed macro).
//  - Sub-module lockstep_ch_slice (WIDTH, CNT_W): one channel compare, sticky, counter;
//    generate-instantiated NCH times. Top holds FSM, cycle_cnt, priority snapshot logic.
// TESTING
//  1 reset high 3 cycles, then gold==dut random for 100 cycles, chk_en=1, SETTLE=4 ->
//    all flags/counts 0, cycle_cnt=96, first_valid=0.
//  2 in ACTIVE at cycle_cnt=10 force ch2 dut bit0 flipped one cycle -> mismatch_now[2] one
//    cycle after, sticky[2]=1, cnt[2]=1, first_ch=2, first_time=10, first_gold/dut differ bit0.
//  3 same edge mismatch on ch1 and ch3 -> first_ch=1, cnt[1]=cnt[3]=1; later ch0 hit does
//    not overwrite snapshot.
//  4 CNT_W=4, ch0 mismatching 20 ACTIVE cycles -> cnt[0]=15 held; ch_mask[0]=0 then
//    mismatch -> no count change, sticky unchanged.
//  5 mismatch during SETTLE (3rd cycle after chk_en rise) -> ignored; chk_en drop for 1
//    cycle then rise -> 4 further uncompared cycles before compares resume.
//  6 clr asserted same edge as ch0 mismatch -> all results 0 next cycle; reset pulse
//    mid-ACTIVE (between edges) -> outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/lockstep_cmp_mon_pkg.sv
// Shared types and helpers for the lockstep gold/DUT comparison monitor.
package lockstep_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE} lk_state_t;

  // Generic saturating increment; callers widen to 64 bits and truncate back.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (val >= max_v) ? val : val + 64'd1;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lockstep_cmp_mon_if.sv
// Bundle of the monitor's qualifier, compared buses and result outputs.
interface lockstep_cmp_mon_if
  import lockstep_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 128,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
);
  localparam int CH_W = ch_width(NCH);

  logic                   chk_en;
  logic                   clr;
  logic [NCH-1:0]         ch_mask;
  logic [NCH*WIDTH-1:0]   gold_bus;
  logic [NCH*WIDTH-1:0]   dut_bus;

  logic [NCH-1:0]         mismatch_now;
  logic [NCH-1:0]         mismatch_sticky;
  logic                   any_err;
  logic [NCH*CNT_W-1:0]   mismatch_cnt;
  logic [TS_W-1:0]        cycle_cnt;
  logic                   first_valid;
  logic [CH_W-1:0]        first_ch;
  logic [TS_W-1:0]        first_time;
  logic [WIDTH-1:0]       first_gold;
  logic [WIDTH-1:0]       first_dut;

  modport master (
    output chk_en, clr, ch_mask, gold_bus, dut_bus,
    input  mismatch_now, mismatch_sticky, any_err, mismatch_cnt, cycle_cnt,
           first_valid, first_ch, first_time, first_gold, first_dut
  );

  modport slave (
    input  chk_en, clr, ch_mask, gold_bus, dut_bus,
    output mismatch_now, mismatch_sticky, any_err, mismatch_cnt, cycle_cnt,
           first_valid, first_ch, first_time, first_gold, first_dut
  );

endinterface

// File: rtl/lockstep_cmp_mon_ch_slice.sv
// One compared channel: registered mismatch, sticky flag and saturating count.
module lockstep_ch_slice
  import lockstep_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk_50,
  input  logic             reset,
  input  logic             clr,
  input  logic             cmp_en,
  input  logic [WIDTH-1:0] gold,
  input  logic [WIDTH-1:0] dut,
  output logic             hit,
  output logic             mismatch_now,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  assign hit = cmp_en && (gold != dut);

  // clr outranks a same-edge hit so a cleared result never starts non-zero.
  always_ff @(posedge sys_clk_50 or posedge reset) begin
    if (reset) begin
      mismatch_now <= 1'b0;
      sticky       <= 1'b0;
      cnt          <= '0;
    end else if (clr) begin
      mismatch_now <= 1'b0;
      sticky       <= 1'b0;
      cnt          <= '0;
    end else begin
      mismatch_now <= hit;
      if (hit) begin
        sticky <= 1'b1;
        cnt    <= CNT_W'(sat_inc(64'(cnt), CNT_W));
      end
    end
  end

endmodule

// File: rtl/lockstep_cmp_mon.sv
// Lockstep monitor top: check-window FSM, active-cycle counter and first-mismatch snapshot.
module lockstep_cmp_mon
  import lockstep_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int WIDTH  = 128,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 32,
  parameter int SETTLE = 4
) (
  input  logic                sys_clk_50,
  input  logic                reset,
  lockstep_cmp_mon_if.slave   mon
);

  localparam int CH_W  = ch_width(NCH);
  // The IDLE->SETTLE edge is itself the first uncompared cycle.
  localparam int SET_W = (SETTLE > 2) ? $clog2(SETTLE - 1) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE > 2) ? SETTLE - 2 : 0);

  lk_state_t            state_q, state_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic                 active;
  logic [NCH-1:0]       cmp_en;
  logic [NCH-1:0]       hit;
  logic [NCH-1:0]       now_bus;
  logic [NCH-1:0]       sticky_bus;
  logic [NCH*CNT_W-1:0] cnt_bus;
  logic [TS_W-1:0]      cycle_q;
  logic                 first_valid_q;
  logic [CH_W-1:0]      first_ch_q, sel_ch;
  logic [TS_W-1:0]      first_time_q;
  logic [WIDTH-1:0]     first_gold_q, first_dut_q, sel_gold, sel_dut;

  always_ff @(posedge sys_clk_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    case (state_q)
      IDLE: begin
        set_d = '0;
        if (mon.chk_en) begin
          if (SETTLE <= 1) state_d = ACTIVE;
          else             state_d = lockstep_pkg::SETTLE;
        end
      end
      lockstep_pkg::SETTLE: begin
        if (set_q == SET_LAST) state_d = ACTIVE;
        else                   set_d   = set_q + 1'b1;
      end
      ACTIVE:  state_d = state_q;
      default: state_d = IDLE;
    endcase
    if (!mon.chk_en) begin
      state_d = IDLE;
      set_d   = '0;
    end
  end

  assign active = (state_q == ACTIVE) && mon.chk_en;
  assign cmp_en = {NCH{active}} & mon.ch_mask;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    lockstep_ch_slice #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slice (
      .sys_clk_50   (sys_clk_50),
      .reset        (reset),
      .clr          (mon.clr),
      .cmp_en       (cmp_en[i]),
      .gold         (mon.gold_bus[i*WIDTH +: WIDTH]),
      .dut          (mon.dut_bus[i*WIDTH +: WIDTH]),
      .hit          (hit[i]),
      .mismatch_now (now_bus[i]),
      .sticky       (sticky_bus[i]),
      .cnt          (cnt_bus[i*CNT_W +: CNT_W])
    );
  end

  // Scan from the top down so the lowest-index hit is the one left selected.
  always_comb begin
    sel_ch   = '0;
    sel_gold = '0;
    sel_dut  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_ch   = CH_W'(i);
        sel_gold = mon.gold_bus[i*WIDTH +: WIDTH];
        sel_dut  = mon.dut_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge sys_clk_50 or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
    end else if (mon.clr) begin
      cycle_q <= '0;
    end else if (active) begin
      cycle_q <= TS_W'(sat_inc(64'(cycle_q), TS_W));
    end
  end

  // The snapshot timestamp is the active-cycle count before this edge's increment.
  always_ff @(posedge sys_clk_50 or posedge reset) begin
    if (reset) begin
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_time_q  <= '0;
      first_gold_q  <= '0;
      first_dut_q   <= '0;
    end else if (mon.clr) begin
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      first_time_q  <= '0;
      first_gold_q  <= '0;
      first_dut_q   <= '0;
    end else if (!first_valid_q && (|hit)) begin
      first_valid_q <= 1'b1;
      first_ch_q    <= sel_ch;
      first_time_q  <= cycle_q;
      first_gold_q  <= sel_gold;
      first_dut_q   <= sel_dut;
    end
  end

  assign mon.mismatch_now    = now_bus;
  assign mon.mismatch_sticky = sticky_bus;
  assign mon.any_err         = |sticky_bus;
  assign mon.mismatch_cnt    = cnt_bus;
  assign mon.cycle_cnt       = cycle_q;
  assign mon.first_valid     = first_valid_q;
  assign mon.first_ch        = first_ch_q;
  assign mon.first_time      = first_time_q;
  assign mon.first_gold      = first_gold_q;
  assign mon.first_dut       = first_dut_q;

endmodule

// File: tb/tb_lockstep_cmp_mon.sv
// Self-checking bench for lockstep_cmp_mon with a rule-level reference model.
module tb_lockstep_cmp_mon;

  localparam int NCH    = 4;
  localparam int WIDTH  = 128;
  localparam int CNT_W  = 4;
  localparam int TS_W   = 32;
  localparam int SETTLE = 4;
  localparam int CH_W   = 2;

  logic sys_clk_50 = 1'b0;
  logic reset      = 1'b1;

  always #10 sys_clk_50 = ~sys_clk_50;

  lockstep_cmp_mon_if #(.NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W), .TS_W(TS_W)) mon_if ();

  lockstep_cmp_mon #(
    .NCH(NCH), .WIDTH(WIDTH), .CNT_W(CNT_W), .TS_W(TS_W), .SETTLE(SETTLE)
  ) dut (
    .sys_clk_50 (sys_clk_50),
    .reset      (reset),
    .mon        (mon_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: results derived from the monitor's rules, not its structure.
  int             m_run;
  logic [NCH-1:0] m_now, m_sticky;
  int             m_cnt [NCH];
  longint         m_cycle;
  logic           m_fv;
  int             m_fch;
  longint         m_ftime;
  logic [WIDTH-1:0] m_fgold, m_fdut;

  task automatic model_reset();
    m_run = 0; m_now = '0; m_sticky = '0; m_cycle = 0;
    m_fv = 1'b0; m_fch = 0; m_ftime = 0; m_fgold = '0; m_fdut = '0;
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    logic           act;
    logic [NCH-1:0] h;
    int             settle_need;
    settle_need = (SETTLE > 1) ? SETTLE : 1;
    act = mon_if.chk_en && (m_run >= settle_need);
    h = '0;
    for (int i = 0; i < NCH; i++)
      if (act && mon_if.ch_mask[i] &&
          mon_if.gold_bus[i*WIDTH +: WIDTH] != mon_if.dut_bus[i*WIDTH +: WIDTH]) h[i] = 1'b1;
    if (mon_if.clr) begin
      m_now = '0; m_sticky = '0; m_cycle = 0;
      m_fv = 1'b0; m_fch = 0; m_ftime = 0; m_fgold = '0; m_fdut = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    end else begin
      m_now = h;
      m_sticky = m_sticky | h;
      for (int i = 0; i < NCH; i++)
        if (h[i] && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
      if (!m_fv && h != '0) begin
        for (int i = NCH - 1; i >= 0; i--) if (h[i]) m_fch = i;
        m_fv = 1'b1;
        m_ftime = m_cycle;
        m_fgold = mon_if.gold_bus[m_fch*WIDTH +: WIDTH];
        m_fdut  = mon_if.dut_bus[m_fch*WIDTH +: WIDTH];
      end
      if (act && m_cycle < (64'd1 << TS_W) - 1) m_cycle++;
    end
    m_run = mon_if.chk_en ? m_run + 1 : 0;
  endtask

  function automatic logic [NCH*CNT_W-1:0] model_cnt_bus();
    logic [NCH*CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge sys_clk_50);
    model_edge();
    #1;
  endtask

  task automatic set_equal_random();
    for (int w = 0; w < NCH*WIDTH/32; w++) mon_if.gold_bus[w*32 +: 32] = $urandom();
    mon_if.dut_bus = mon_if.gold_bus;
  endtask

  task automatic flip_ch(input int ch, input logic [WIDTH-1:0] pat);
    mon_if.dut_bus[ch*WIDTH +: WIDTH] = mon_if.gold_bus[ch*WIDTH +: WIDTH] ^ pat;
  endtask

  function automatic logic [WIDTH-1:0] rand_pat();
    logic [WIDTH-1:0] p;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    p[$urandom_range(0, WIDTH-1)] = 1'b1;
    return p;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    mon_if.chk_en = 1'b0; mon_if.clr = 1'b0; mon_if.ch_mask = '1;
    set_equal_random();
    model_reset();
    repeat (3) @(posedge sys_clk_50);
    #1;
    checks++; if (mon_if.any_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_any_err: got %0b expected 0", mon_if.any_err); end
    checks++; if (mon_if.mismatch_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0h expected 0", mon_if.mismatch_cnt); end
    checks++; if (mon_if.cycle_cnt !== '0) begin errors++; $display("[TB] FAIL reset_cycle: got %0d expected 0", mon_if.cycle_cnt); end
    checks++; if (mon_if.first_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_valid: got %0b expected 0", mon_if.first_valid); end
    @(negedge sys_clk_50);
    reset = 1'b0;
  endtask

  task automatic test_clean_window();
    mon_if.chk_en = 1'b1;
    repeat (100) begin set_equal_random(); tick(); end
    checks++; if (mon_if.cycle_cnt !== 32'd96) begin errors++; $display("[TB] FAIL clean_cycle: got %0d expected 96", mon_if.cycle_cnt); end
    checks++; if (mon_if.mismatch_sticky !== '0) begin errors++; $display("[TB] FAIL clean_sticky: got %b expected 0000", mon_if.mismatch_sticky); end
    checks++; if (mon_if.mismatch_cnt !== '0) begin errors++; $display("[TB] FAIL clean_cnt: got %0h expected 0", mon_if.mismatch_cnt); end
    checks++; if (mon_if.first_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_first_valid: got %0b expected 0", mon_if.first_valid); end
  endtask

  task automatic test_single_flip();
    logic [WIDTH-1:0] g;
    mon_if.clr = 1'b1; set_equal_random(); tick(); mon_if.clr = 1'b0;
    repeat (10) begin set_equal_random(); tick(); end
    checks++; if (mon_if.cycle_cnt !== 32'd10) begin errors++; $display("[TB] FAIL flip_pre_cycle: got %0d expected 10", mon_if.cycle_cnt); end
    set_equal_random();
    flip_ch(2, 128'h1);
    g = mon_if.gold_bus[2*WIDTH +: WIDTH];
    tick();
    checks++; if (mon_if.mismatch_now !== 4'b0100) begin errors++; $display("[TB] FAIL flip_now: got %b expected 0100", mon_if.mismatch_now); end
    checks++; if (mon_if.mismatch_sticky !== 4'b0100) begin errors++; $display("[TB] FAIL flip_sticky: got %b expected 0100", mon_if.mismatch_sticky); end
    checks++; if (mon_if.mismatch_cnt !== 16'h0100) begin errors++; $display("[TB] FAIL flip_cnt: got %h expected 0100", mon_if.mismatch_cnt); end
    checks++; if (mon_if.first_ch !== CH_W'(2)) begin errors++; $display("[TB] FAIL flip_first_ch: got %0d expected 2", mon_if.first_ch); end
    checks++; if (mon_if.first_time !== 32'd10) begin errors++; $display("[TB] FAIL flip_first_time: got %0d expected 10", mon_if.first_time); end
    checks++; if (mon_if.first_gold !== g) begin errors++; $display("[TB] FAIL flip_first_gold: got %h expected %h", mon_if.first_gold, g); end
    checks++; if (mon_if.first_dut !== (g ^ 128'h1)) begin errors++; $display("[TB] FAIL flip_first_dut: got %h expected %h", mon_if.first_dut, g ^ 128'h1); end
    set_equal_random(); tick();
    checks++; if (mon_if.mismatch_now !== 4'b0000) begin errors++; $display("[TB] FAIL flip_now_after: got %b expected 0000", mon_if.mismatch_now); end
    checks++; if (mon_if.mismatch_sticky !== 4'b0100) begin errors++; $display("[TB] FAIL flip_sticky_after: got %b expected 0100", mon_if.mismatch_sticky); end
  endtask

  task automatic test_tie_priority();
    mon_if.clr = 1'b1; set_equal_random(); tick(); mon_if.clr = 1'b0;
    repeat (3) begin set_equal_random(); tick(); end
    set_equal_random(); flip_ch(1, rand_pat()); flip_ch(3, rand_pat()); tick();
    checks++; if (mon_if.first_ch !== CH_W'(1)) begin errors++; $display("[TB] FAIL tie_first_ch: got %0d expected 1", mon_if.first_ch); end
    checks++; if (mon_if.first_time !== 32'd3) begin errors++; $display("[TB] FAIL tie_first_time: got %0d expected 3", mon_if.first_time); end
    checks++; if (mon_if.mismatch_cnt !== 16'h1010) begin errors++; $display("[TB] FAIL tie_cnt: got %h expected 1010", mon_if.mismatch_cnt); end
    set_equal_random(); tick();
    set_equal_random(); flip_ch(0, rand_pat()); tick();
    checks++; if (mon_if.first_ch !== CH_W'(1)) begin errors++; $display("[TB] FAIL tie_keep_ch: got %0d expected 1", mon_if.first_ch); end
    checks++; if (mon_if.first_time !== 32'd3) begin errors++; $display("[TB] FAIL tie_keep_time: got %0d expected 3", mon_if.first_time); end
    checks++; if (mon_if.mismatch_sticky !== 4'b1011) begin errors++; $display("[TB] FAIL tie_sticky: got %b expected 1011", mon_if.mismatch_sticky); end
    checks++; if (mon_if.mismatch_cnt !== 16'h1011) begin errors++; $display("[TB] FAIL tie_cnt_late: got %h expected 1011", mon_if.mismatch_cnt); end
  endtask

  task automatic test_saturation_mask();
    mon_if.clr = 1'b1; set_equal_random(); tick(); mon_if.clr = 1'b0;
    mon_if.ch_mask = 4'b1110;
    repeat (3) begin set_equal_random(); flip_ch(0, rand_pat()); tick(); end
    checks++; if (mon_if.mismatch_sticky !== 4'b0000) begin errors++; $display("[TB] FAIL mask_sticky_pre: got %b expected 0000", mon_if.mismatch_sticky); end
    mon_if.ch_mask = 4'b1111;
    repeat (20) begin set_equal_random(); flip_ch(0, rand_pat()); tick(); end
    checks++; if (mon_if.mismatch_cnt !== 16'h000F) begin errors++; $display("[TB] FAIL sat_cnt: got %h expected 000f", mon_if.mismatch_cnt); end
    mon_if.ch_mask = 4'b1110;
    repeat (3) begin set_equal_random(); flip_ch(0, rand_pat()); tick(); end
    checks++; if (mon_if.mismatch_cnt !== 16'h000F) begin errors++; $display("[TB] FAIL mask_cnt_frozen: got %h expected 000f", mon_if.mismatch_cnt); end
    checks++; if (mon_if.mismatch_sticky !== 4'b0001) begin errors++; $display("[TB] FAIL mask_sticky_kept: got %b expected 0001", mon_if.mismatch_sticky); end
    checks++; if (mon_if.mismatch_now !== 4'b0000) begin errors++; $display("[TB] FAIL mask_now: got %b expected 0000", mon_if.mismatch_now); end
    mon_if.ch_mask = 4'b1111;
  endtask

  task automatic test_settle();
    int n;
    mon_if.chk_en = 1'b0; mon_if.clr = 1'b1; set_equal_random(); tick(); mon_if.clr = 1'b0;
    mon_if.chk_en = 1'b1;
    set_equal_random(); tick();
    set_equal_random(); tick();
    set_equal_random(); flip_ch(0, rand_pat()); tick();
    set_equal_random(); tick();
    checks++; if (mon_if.mismatch_sticky !== 4'b0000) begin errors++; $display("[TB] FAIL settle_ignored: got %b expected 0000", mon_if.mismatch_sticky); end
    checks++; if (mon_if.cycle_cnt !== 32'd0) begin errors++; $display("[TB] FAIL settle_cycle: got %0d expected 0", mon_if.cycle_cnt); end
    set_equal_random(); tick();
    checks++; if (mon_if.cycle_cnt !== 32'd1) begin errors++; $display("[TB] FAIL settle_first_active: got %0d expected 1", mon_if.cycle_cnt); end
    mon_if.chk_en = 1'b0; set_equal_random(); tick();
    mon_if.chk_en = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      set_equal_random(); flip_ch(1, rand_pat()); tick();
      if (mon_if.mismatch_now[1]) break;
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL settle_reentry: got %0d uncompared cycles expected 4", n); end
  endtask

  task automatic test_clr_and_reset();
    set_equal_random(); flip_ch(0, rand_pat()); mon_if.clr = 1'b1; tick(); mon_if.clr = 1'b0;
    checks++; if (mon_if.mismatch_sticky !== 4'b0000) begin errors++; $display("[TB] FAIL clr_sticky: got %b expected 0000", mon_if.mismatch_sticky); end
    checks++; if (mon_if.mismatch_cnt !== '0) begin errors++; $display("[TB] FAIL clr_cnt: got %h expected 0", mon_if.mismatch_cnt); end
    checks++; if (mon_if.cycle_cnt !== 32'd0) begin errors++; $display("[TB] FAIL clr_cycle: got %0d expected 0", mon_if.cycle_cnt); end
    checks++; if (mon_if.first_valid !== 1'b0 || mon_if.mismatch_now !== 4'b0000) begin errors++; $display("[TB] FAIL clr_first_now: got %0b/%b expected 0/0000", mon_if.first_valid, mon_if.mismatch_now); end
    set_equal_random(); flip_ch(2, rand_pat()); tick();
    checks++; if (mon_if.first_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_recapture: got %0b expected 1", mon_if.first_valid); end
    @(negedge sys_clk_50);
    reset = 1'b1;
    #1;
    model_reset();
    checks++; if (mon_if.mismatch_sticky !== '0 || mon_if.any_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_sticky: got %b/%0b expected 0000/0", mon_if.mismatch_sticky, mon_if.any_err); end
    checks++; if (mon_if.mismatch_cnt !== '0 || mon_if.cycle_cnt !== '0) begin errors++; $display("[TB] FAIL rst_counts: got %h/%0d expected 0/0", mon_if.mismatch_cnt, mon_if.cycle_cnt); end
    checks++; if (mon_if.first_valid !== 1'b0 || mon_if.first_gold !== '0 || mon_if.first_dut !== '0) begin errors++; $display("[TB] FAIL rst_snapshot: got %0b/%h/%h expected all 0", mon_if.first_valid, mon_if.first_gold, mon_if.first_dut); end
    @(posedge sys_clk_50);
    @(negedge sys_clk_50);
    reset = 1'b0;
    set_equal_random(); flip_ch(3, rand_pat()); tick();
    checks++; if (mon_if.mismatch_sticky !== 4'b0000) begin errors++; $display("[TB] FAIL rst_idle: got %b expected 0000", mon_if.mismatch_sticky); end
  endtask

  task automatic test_random();
    mon_if.clr = 1'b1; set_equal_random(); tick(); mon_if.clr = 1'b0;
    for (int t = 0; t < 300; t++) begin
      mon_if.chk_en = ($urandom_range(0, 9) != 0);
      mon_if.clr    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) mon_if.ch_mask = NCH'($urandom());
      set_equal_random();
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 4) == 0) flip_ch(c, rand_pat());
      tick();
      checks++; if (mon_if.mismatch_now !== m_now) begin errors++; $display("[TB] FAIL rnd_now@%0d: got %b expected %b", t, mon_if.mismatch_now, m_now); end
      checks++; if (mon_if.mismatch_sticky !== m_sticky) begin errors++; $display("[TB] FAIL rnd_sticky@%0d: got %b expected %b", t, mon_if.mismatch_sticky, m_sticky); end
      checks++; if (mon_if.mismatch_cnt !== model_cnt_bus()) begin errors++; $display("[TB] FAIL rnd_cnt@%0d: got %h expected %h", t, mon_if.mismatch_cnt, model_cnt_bus()); end
      checks++; if (mon_if.cycle_cnt !== TS_W'(m_cycle)) begin errors++; $display("[TB] FAIL rnd_cycle@%0d: got %0d expected %0d", t, mon_if.cycle_cnt, m_cycle); end
      checks++; if (mon_if.first_valid !== m_fv) begin errors++; $display("[TB] FAIL rnd_first_valid@%0d: got %0b expected %0b", t, mon_if.first_valid, m_fv); end
      if (m_fv) begin
        checks++; if (mon_if.first_ch !== CH_W'(m_fch) || mon_if.first_time !== TS_W'(m_ftime)) begin errors++; $display("[TB] FAIL rnd_first_id@%0d: got ch%0d t%0d expected ch%0d t%0d", t, mon_if.first_ch, mon_if.first_time, m_fch, m_ftime); end
        checks++; if (mon_if.first_gold !== m_fgold || mon_if.first_dut !== m_fdut) begin errors++; $display("[TB] FAIL rnd_first_words@%0d: got %h/%h expected %h/%h", t, mon_if.first_gold, mon_if.first_dut, m_fgold, m_fdut); end
      end
    end
    mon_if.clr = 1'b0;
  endtask

  initial begin
    $display("[TB] lockstep_cmp_mon bench start");
    test_reset();
    test_clean_window();
    test_single_flip();
    test_tie_priority();
    test_saturation_mask();
    test_settle();
    test_clr_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
